bin_row_writer: RTL

- Binarizes the dual-pixel camera stream against a threshold and packs each video line into one MDATA_WIDTH-bit row word.
- Writes each row word to the row-bitmap memory at address = line index.
- It is the producer side of the bitmap memory that the centre-of-gravity calculator scans row by row (addresses 0..MAX_Y_ADDR-1).
- Pulses frame-done so the consumer can start its scan.

---
 rtl/bin_row_writer_pkg.sv | 20 ++
 rtl/bin_row_writer_det_edge.sv | 37 +++
 rtl/bin_row_writer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bin_row_writer_pkg.sv
// rtl/bin_row_writer_pkg.sv - shared row-bitmap geometry and writer FSM encoding
//
// Geometry constants are shared with the centre-of-gravity calculator so that
// the producer and consumer of the bitmap memory agree on row width and count.
package bin_row_writer_pkg;

  localparam int BRW_ADDR_WIDTH  = 11;
  localparam int BRW_MDATA_WIDTH = 640;
  localparam int BRW_MAX_Y_ADDR  = 480;
  localparam int BRW_PIXEL_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINE = 3'd1,
    ST_ACCUM     = 3'd2,
    ST_WRITE     = 3'd3,
    ST_DONE      = 3'd4
  } brw_state_e;

endpackage

// File: rtl/bin_row_writer_det_edge.sv
// rtl/bin_row_writer_det_edge.sv - rise/fall detector for a synchronous level input
//
// Ports:
//   CCLK   clock
//   RST_N  asynchronous active-low reset
//   iSIG   level to watch
//   oRISE  high in the cycle iSIG is first sampled high
//   oFALL  high in the cycle iSIG is first sampled low
//
// The detector stays disarmed for the first cycle after reset, so a level that
// is already high when reset releases is loaded silently instead of being
// reported as a rising edge.
module DET_EDGE (
  input  logic CCLK,
  input  logic RST_N,
  input  logic iSIG,
  output logic oRISE,
  output logic oFALL
);

  logic sig_d;
  logic armed;

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      sig_d <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_d <= iSIG;
      armed <= 1'b1;
    end
  end

  assign oRISE = armed &  iSIG & ~sig_d;
  assign oFALL = armed & ~iSIG &  sig_d;

endmodule

// File: rtl/bin_row_writer.sv
// rtl/bin_row_writer.sv - binarize dual-pixel lines and write one packed row word per line
//
// Ports:
//   CCLK, RST_N          clock, asynchronous active-low reset
//   iTHRESHOLD           pixel > threshold gives a 1 bit
//   iFVAL, iLVAL         frame / line valid levels
//   iPIX_EN              qualifies the iDATA_L / iDATA_R pixel pair
//   iDATA_L, iDATA_R     even / odd column pixel of the pair
//   oWE, oADDR, oMEMOUT  one-cycle row write to the bitmap memory
//   oFRAME_DONE          one-cycle pulse once the frame has been fully written
//   oROW_COUNT           rows written in the last completed frame
//   oOVERFLOW            a line beyond the last storable row was dropped this frame
//
// Outputs are registered on the transition into a state, so oWE is high exactly
// while the FSM sits in WRITE and oFRAME_DONE exactly while it sits in DONE;
// the two can therefore never coincide.
module bin_row_writer
  import bin_row_writer_pkg::*;
#(
  parameter int ADDR_WIDTH  = BRW_ADDR_WIDTH,
  parameter int MDATA_WIDTH = BRW_MDATA_WIDTH,
  parameter int MAX_Y_ADDR  = BRW_MAX_Y_ADDR,
  parameter int PIXEL_WIDTH = BRW_PIXEL_WIDTH
) (
  input  logic                   CCLK,
  input  logic                   RST_N,
  input  logic [PIXEL_WIDTH-1:0] iTHRESHOLD,
  input  logic                   iFVAL,
  input  logic                   iLVAL,
  input  logic                   iPIX_EN,
  input  logic [PIXEL_WIDTH-1:0] iDATA_L,
  input  logic [PIXEL_WIDTH-1:0] iDATA_R,
  output logic                   oWE,
  output logic [ADDR_WIDTH-1:0]  oADDR,
  output logic [MDATA_WIDTH-1:0] oMEMOUT,
  output logic                   oFRAME_DONE,
  output logic [ADDR_WIDTH-1:0]  oROW_COUNT,
  output logic                   oOVERFLOW
);

  localparam int PAIRS = MDATA_WIDTH / 2;
  // One extra count value so col can sit at PAIRS once the row is full.
  localparam int COL_W = $clog2(PAIRS + 1);

  brw_state_e             state;
  logic [ADDR_WIDTH-1:0]  row;
  logic [COL_W-1:0]       col;
  logic [MDATA_WIDTH-1:0] row_buf;

  logic fval_rise, fval_fall;
  logic lval_rise, lval_fall;
  logic [1:0] pair_bits;

  DET_EDGE u_det_fval (
    .CCLK  (CCLK),
    .RST_N (RST_N),
    .iSIG  (iFVAL),
    .oRISE (fval_rise),
    .oFALL (fval_fall)
  );

  DET_EDGE u_det_lval (
    .CCLK  (CCLK),
    .RST_N (RST_N),
    .iSIG  (iLVAL),
    .oRISE (lval_rise),
    .oFALL (lval_fall)
  );

  // Bit 2c is the even-column (L) pixel, bit 2c+1 the odd-column (R) pixel.
  assign pair_bits = {iDATA_R > iTHRESHOLD, iDATA_L > iTHRESHOLD};

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      row_buf     <= '0;
      oWE         <= 1'b0;
      oADDR       <= '0;
      oMEMOUT     <= '0;
      oFRAME_DONE <= 1'b0;
      oROW_COUNT  <= '0;
      oOVERFLOW   <= 1'b0;
    end else begin
      oWE         <= 1'b0;
      oFRAME_DONE <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (fval_rise) begin
            row       <= '0;
            oOVERFLOW <= 1'b0;
            state     <= ST_WAIT_LINE;
          end
        end

        ST_WAIT_LINE: begin
          if (fval_fall) begin
            oFRAME_DONE <= 1'b1;
            oROW_COUNT  <= row;
            state       <= ST_DONE;
          end else if (lval_rise) begin
            // The pair presented with the line's first cycle belongs to column 0.
            row_buf <= '0;
            col     <= '0;
            if (iPIX_EN) begin
              row_buf[1:0] <= pair_bits;
              col          <= COL_W'(1);
            end
            state <= ST_ACCUM;
          end
        end

        ST_ACCUM: begin
          // A frame ending mid-line closes the line just like a line end.
          if (lval_fall || fval_fall) begin
            if (row < ADDR_WIDTH'(MAX_Y_ADDR)) begin
              oWE     <= 1'b1;
              oADDR   <= row;
              oMEMOUT <= row_buf;
              row     <= row + 1'b1;
            end else begin
              oOVERFLOW <= 1'b1;
            end
            state <= ST_WRITE;
          end else if (iLVAL && iPIX_EN && (col < COL_W'(PAIRS))) begin
            row_buf[{col, 1'b0} +: 2] <= pair_bits;
            col                       <= col + 1'b1;
          end
        end

        ST_WRITE: begin
          // Level check rather than edge: the fall may have coincided with the
          // line end already consumed in ACCUM.
          if (!iFVAL) begin
            oFRAME_DONE <= 1'b1;
            oROW_COUNT  <= row;
            state       <= ST_DONE;
          end else begin
            state <= ST_WAIT_LINE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
